// File: rtl/aes_pt_buffer_if.sv
// Handshake bundle between the AES decrypt pipeline, the plaintext buffer
// and its downstream consumer.
interface aes_pt_buffer_if;
    logic         load;
    logic         pt_valid;
    logic [127:0] pt;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         load_ok;
    logic         overflow;
    logic         bad_load;

    modport slave (
        input  load, pt_valid, pt, out_ready,
        output out_valid, out_data, load_ok, overflow, bad_load
    );

    modport master (
        output load, pt_valid, pt, out_ready,
        input  out_valid, out_data, load_ok, overflow, bad_load
    );
endinterface

// File: rtl/aes_pt_buffer.sv
// Plaintext buffer behind a non-stallable AES decrypt pipeline: FWFT FIFO plus
// an in-flight credit counter that tells the issuer when a new load is safe.
module aes_pt_buffer #(
    parameter int DEPTH = 4,
    parameter int LAT   = 12
) (
    input  logic          clk,
    input  logic          rst_b,
    aes_pt_buffer_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // LAT only documents the pipeline; the credit scheme is timing-agnostic.
    generate
        if (DEPTH < 2 || DEPTH > 16 || LAT < 1) begin : g_param_check
            $error("aes_pt_buffer: DEPTH must be 2..16 and LAT positive");
        end
    endgenerate

    logic [127:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] infl_q, infl_d;
    logic          overflow_q, overflow_d;
    logic          bad_load_q, bad_load_d;
    logic          push, pop, load_ok;
    logic [CW:0]   credit_used;

    always_comb begin
        pop         = (occ_q != '0) && bus.out_ready;
        push        = bus.pt_valid && ((occ_q != FULL) || pop);
        credit_used = {1'b0, occ_q} + {1'b0, infl_q};
        load_ok     = credit_used < {1'b0, FULL};

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        // Credit saturates at DEPTH on illegal loads and never goes below zero.
        infl_d = infl_q;
        if (bus.load && !bus.pt_valid && (infl_q != FULL)) begin
            infl_d = infl_q + 1'b1;
        end else if (bus.pt_valid && !bus.load && (infl_q != '0)) begin
            infl_d = infl_q - 1'b1;
        end

        overflow_d = overflow_q | (bus.pt_valid && (occ_q == FULL) && !pop);
        bad_load_d = bad_load_q | (bus.load && !load_ok);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            infl_q     <= '0;
            overflow_q <= 1'b0;
            bad_load_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            infl_q     <= infl_d;
            overflow_q <= overflow_d;
            bad_load_q <= bad_load_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.pt;
        end
    end

    assign bus.out_valid = (occ_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.load_ok   = load_ok;
    assign bus.overflow  = overflow_q;
    assign bus.bad_load  = bad_load_q;
endmodule

// File: tb/tb_aes_pt_buffer.sv
// Self-checking bench for aes_pt_buffer against a queue-based reference model.
module tb_aes_pt_buffer;
    localparam int DEPTH = 4;
    localparam int LAT   = 12;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    aes_pt_buffer_if bus();

    aes_pt_buffer #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Reference model: queue of buffered plaintexts, credit count, sticky flags.
    logic [127:0] mq[$];
    int           m_infl;
    bit           m_ovf;
    bit           m_bad;

    function automatic bit m_load_ok();
        return (mq.size() + m_infl) < DEPTH;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_infl = 0;
        m_ovf  = 0;
        m_bad  = 0;
    endtask

    task automatic idle_inputs();
        bus.load      = 1'b0;
        bus.pt_valid  = 1'b0;
        bus.pt        = '0;
        bus.out_ready = 1'b0;
    endtask

    // Advance one clock; model consumes the inputs seen at the edge.
    task automatic tick();
        bit pv, ld, lok, pop, can_push;
        logic [127:0] d, tmp;
        pv       = bus.pt_valid;
        ld       = bus.load;
        d        = bus.pt;
        lok      = m_load_ok();
        pop      = (mq.size() != 0) && bus.out_ready;
        can_push = pv && ((mq.size() < DEPTH) || pop);
        @(posedge clk);
        #1;
        cycle++;
        if (!rst_b) begin
            model_clear();
        end else begin
            if (ld && !lok) m_bad = 1;
            if (pv && !can_push) m_ovf = 1;
            if (pop) tmp = mq.pop_front();
            if (can_push) mq.push_back(d);
            if (ld && !pv) m_infl = (m_infl + 1 > DEPTH) ? DEPTH : m_infl + 1;
            else if (pv && !ld && m_infl > 0) m_infl = m_infl - 1;
        end
    endtask

    task automatic test_reset();
        logic [127:0] d;
        idle_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.load_ok !== 1'b1) begin n_fail++; $display("FAIL reset_load_ok: got %b expected 1", bus.load_ok); end
        n_checks++;
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        n_checks++;
        if (bus.bad_load !== 1'b0) begin n_fail++; $display("FAIL reset_bad_load: got %b expected 0", bus.bad_load); end
        rst_b = 1'b1;
        d = rnd128();
        bus.pt_valid = 1'b1;
        bus.pt = d;
        tick();
        bus.pt_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== d) begin
            n_fail++; $display("FAIL first_push_after_reset: got v=%b %h expected v=1 %h", bus.out_valid, bus.out_data, d);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.load_ok !== 1'b1) begin
            n_fail++; $display("FAIL pop_after_reset: got v=%b ok=%b expected v=0 ok=1", bus.out_valid, bus.load_ok);
        end
        $display("test_reset done at cycle %0d", cycle);
    endtask

    task automatic test_single_block();
        logic [127:0] d;
        d = 128'h00112233445566778899aabbccddeeff;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            n_checks++;
            if ({bus.out_valid, bus.load_ok} !== 2'b01) begin
                n_fail++; $display("FAIL single_wait c%0d: got v=%b ok=%b expected v=0 ok=1", i, bus.out_valid, bus.load_ok);
            end
            tick();
        end
        bus.pt_valid  = 1'b1;
        bus.pt        = d;
        bus.out_ready = 1'b1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b expected 0", bus.out_valid); end
        tick();
        bus.pt_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.load_ok !== 1'b1) begin
            n_fail++; $display("FAIL single_out: got v=%b ok=%b %h expected v=1 ok=1 %h", bus.out_valid, bus.load_ok, bus.out_data, d);
        end
        tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b expected 0", bus.out_valid); end
        $display("test_single_block pt=%h", d);
    endtask

    task automatic test_credit_fill();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (bus.load_ok !== 1'b1) begin n_fail++; $display("FAIL credit_load_ok_%0d: got %b expected 1", i, bus.load_ok); end
            bus.load = 1'b1;
            tick();
        end
        bus.load = 1'b0;
        n_checks++;
        if (bus.load_ok !== 1'b0) begin n_fail++; $display("FAIL credit_exhausted: got %b expected 0", bus.load_ok); end
        for (int i = 0; i < DEPTH; i++) begin
            bus.pt_valid = 1'b1;
            bus.pt = rnd128();
            tick();
            n_checks++;
            if (bus.load_ok !== 1'b0) begin n_fail++; $display("FAIL credit_fill_%0d: got %b expected 0", i, bus.load_ok); end
        end
        bus.pt_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== mq[0]) begin
            n_fail++; $display("FAIL credit_head: got v=%b %h expected v=1 %h", bus.out_valid, bus.out_data, mq[0]);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.load_ok !== 1'b1) begin n_fail++; $display("FAIL credit_after_pop: got %b expected 1", bus.load_ok); end
        bus.pt_valid = 1'b1;
        bus.pt = rnd128();
        tick();
        bus.pt_valid = 1'b0;
        $display("test_credit_fill occupancy=%0d", mq.size());
    endtask

    task automatic test_full_simultaneous();
        for (int i = 0; i < 3; i++) begin
            bus.pt_valid  = 1'b1;
            bus.pt        = rnd128();
            bus.out_ready = 1'b1;
            n_checks++;
            if (bus.out_data !== mq[0]) begin n_fail++; $display("FAIL full_sim_pop_%0d: got %h expected %h", i, bus.out_data, mq[0]); end
            tick();
        end
        idle_inputs();
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.load_ok !== 1'b0) begin
            n_fail++; $display("FAIL full_sim_state: got ovf=%b ok=%b expected ovf=0 ok=0", bus.overflow, bus.load_ok);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== mq[0]) begin
                n_fail++; $display("FAIL full_sim_drain_%0d: got v=%b %h expected v=1 %h", i, bus.out_valid, bus.out_data, mq[0]);
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_sim_empty: got %b expected 0", bus.out_valid); end
        $display("test_full_simultaneous done at cycle %0d", cycle);
    endtask

    task automatic test_overflow();
        logic [127:0] dropped;
        for (int i = 0; i < DEPTH; i++) begin
            bus.pt_valid = 1'b1;
            bus.pt = rnd128();
            tick();
        end
        dropped = rnd128();
        bus.pt = dropped;
        tick();
        bus.pt_valid = 1'b0;
        n_checks++;
        if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b expected 1", bus.overflow); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== mq[0] || bus.out_data === dropped) begin
                n_fail++; $display("FAIL overflow_contents_%0d: got v=%b %h expected v=1 %h", i, bus.out_valid, bus.out_data, mq[0]);
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow_sticky: got v=%b ovf=%b expected v=0 ovf=1", bus.out_valid, bus.overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            bus.load = 1'b1;
            tick();
        end
        n_checks++;
        if (bus.load_ok !== 1'b0 || bus.bad_load !== 1'b0) begin
            n_fail++; $display("FAIL bad_load_pre: got ok=%b bad=%b expected ok=0 bad=0", bus.load_ok, bus.bad_load);
        end
        tick();
        bus.load = 1'b0;
        tick();
        n_checks++;
        if (bus.bad_load !== 1'b1 || bus.bad_load !== m_bad) begin
            n_fail++; $display("FAIL bad_load_set: got %b expected 1", bus.bad_load);
        end
        rst_b = 1'b0;
        #1;
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.bad_load !== 1'b0) begin
            n_fail++; $display("FAIL flags_cleared_by_reset: got ovf=%b bad=%b expected 0 0", bus.overflow, bus.bad_load);
        end
        tick();
        rst_b = 1'b1;
        $display("test_overflow dropped=%h", dropped);
    endtask

    task automatic test_streaming();
        int loads = 0;
        int pops  = 0;
        int last_due = 0;
        int due[$];
        int nd, tmp;
        idle_inputs();
        for (int c = 0; c < 600 && pops < 20; c++) begin
            bus.out_ready = (c % 2 == 0);
            bus.load = (loads < 20) && m_load_ok();
            if (bus.load) begin
                nd = cycle + LAT + int'($urandom_range(0, 2));
                if (nd <= last_due) nd = last_due + 1;
                last_due = nd;
                due.push_back(nd);
                loads++;
            end
            bus.pt_valid = (due.size() != 0) && (due[0] == cycle);
            if (bus.pt_valid) begin
                tmp = due.pop_front();
                bus.pt = rnd128();
            end
            n_checks++;
            if (bus.load_ok !== m_load_ok() || bus.out_valid !== (mq.size() != 0)) begin
                n_fail++; $display("FAIL stream_flags c%0d: got ok=%b v=%b expected ok=%b v=%b", cycle, bus.load_ok, bus.out_valid, m_load_ok(), mq.size() != 0);
            end
            if (mq.size() != 0 && bus.out_ready) begin
                n_checks++;
                if (bus.out_data !== mq[0]) begin
                    n_fail++; $display("FAIL stream_data_%0d: got %h expected %h", pops, bus.out_data, mq[0]);
                end
                $display("stream pop %0d data=%h", pops, mq[0]);
                pops++;
            end
            tick();
        end
        idle_inputs();
        n_checks++;
        if (pops != 20) begin n_fail++; $display("FAIL stream_count: got %0d pops expected 20 (timeout)", pops); end
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.bad_load !== 1'b0) begin
            n_fail++; $display("FAIL stream_errors: got ovf=%b bad=%b expected 0 0", bus.overflow, bus.bad_load);
        end
    endtask

    task automatic test_reset_midstream();
        logic [127:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            bus.load = 1'b1;
            tick();
        end
        bus.load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.pt_valid = 1'b1;
            bus.pt = rnd128();
            tick();
        end
        bus.pt_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.load_ok !== 1'b0 || mq.size() != 3 || m_infl != 1) begin
            n_fail++; $display("FAIL midstream_setup: got v=%b ok=%b expected v=1 ok=0", bus.out_valid, bus.load_ok);
        end
        rst_b = 1'b0;
        #2;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.load_ok !== 1'b1) begin
            n_fail++; $display("FAIL midstream_async: got v=%b ok=%b expected v=0 ok=1", bus.out_valid, bus.load_ok);
        end
        model_clear();
        #1;
        rst_b = 1'b1;
        d = rnd128();
        bus.pt_valid = 1'b1;
        bus.pt = d;
        tick();
        bus.pt_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.load_ok !== 1'b1) begin
            n_fail++; $display("FAIL midstream_resume: got v=%b ok=%b %h expected v=1 ok=1 %h", bus.out_valid, bus.load_ok, bus.out_data, d);
        end
        $display("test_reset_midstream resume pt=%h", d);
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_credit_fill();
        test_full_simultaneous();
        test_overflow();
        test_streaming();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/aes_pt_buffer.md
AES_PT_BUFFER -- requirements
Module: aes_pt_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of 128-bit plaintext entries; legal range 2..16.
REQ-002 The block SHALL have parameter LAT, default 12, giving the decrypt-pipeline latency in cycles from load to pt_valid (Nr+2 for Nk=4).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_b  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  copy of the load strobe issued to the decrypt pipeline; one block enters flight per high cycle.
REQ-006 pt_valid  input  1  decrypt output strobe; cannot be stalled.
REQ-007 pt  input  128  plaintext; sampled only when pt_valid=1.
REQ-008 out_valid  output  1  head entry available.
REQ-009 out_ready  input  1  consumer accepts the head entry.
REQ-010 out_data  output  128  head entry plaintext.
REQ-011 load_ok  output  1  a new load may be issued this cycle without risk of overflow.
REQ-012 overflow  output  1  sticky error: a pt_valid arrived while the buffer was full and no pop occurred.
REQ-013 bad_load  output  1  sticky error: load asserted while load_ok=0.

Function
REQ-014 Storage SHALL be a DEPTH-entry circular FIFO with read/write pointers wrapping modulo DEPTH and an occupancy counter of width $clog2(DEPTH+1).
REQ-015 Push SHALL occur when pt_valid=1 and (occupancy<DEPTH or pop occurs in the same cycle); pt is written at the write pointer.
REQ-016 Pop SHALL occur when out_valid=1 and out_ready=1; the read pointer advances.
REQ-017 out_valid SHALL equal (occupancy!=0); out_data SHALL equal the entry at the read pointer; out_data is unspecified when out_valid=0.
REQ-018 Latency: pt_valid at cycle N into an empty buffer SHALL give out_valid=1 with out_data=pt at cycle N+1 (first-word-fall-through, no bypass at cycle N).
REQ-019 Simultaneous push and pop SHALL leave occupancy unchanged; push while full with pop SHALL succeed.
REQ-020 An inflight counter (width $clog2(DEPTH+1)) SHALL increment on load, decrement on pt_valid, and remain unchanged when both occur in the same cycle.
REQ-021 load_ok SHALL be registered-state combinational: load_ok = (occupancy + inflight) < DEPTH.
REQ-022 overflow SHALL set on pt_valid=1 with occupancy=DEPTH and no pop; the pt data SHALL be dropped, with FIFO contents and pointers unchanged.
REQ-023 bad_load SHALL set when load=1 and load_ok=0; inflight SHALL still increment, saturating at DEPTH.
REQ-024 pt_valid with inflight=0 SHALL not underflow: inflight stays 0 and the push proceeds normally.
REQ-025 overflow and bad_load SHALL remain set until reset.
REQ-026 Entries SHALL be delivered in pt_valid order with no loss or duplication when load_ok is honoured.
REQ-027 LAT SHALL be informational and design-checked only; the block SHALL not rely on fixed timing between load and pt_valid.

Reset
REQ-028 While rst_b=0: occupancy=0, inflight=0, pointers=0, out_valid=0, load_ok=1, overflow=0, bad_load=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries and inflight credit immediately (asynchronously); storage array contents need not be cleared.
REQ-030 After rst_b deasserts, the first push SHALL be accepted on the first rising edge with rst_b=1.

Verification
REQ-031 Single block: load at cycle 0, pt_valid with pt=0x00112233445566778899aabbccddeeff at cycle 12, out_ready=1 -> out_valid=1 with that data at cycle 13 only; load_ok stays 1.
REQ-032 Credit fill, DEPTH=4, out_ready=0: four loads on cycles 0-3 -> load_ok=0 from cycle 4; pt_valid ×4 -> occupancy 4, load_ok stays 0; one pop -> load_ok=1 the next cycle.
REQ-033 Full plus simultaneous: occupancy=4, pt_valid and out_ready in the same cycle -> occupancy stays 4, overflow=0, order preserved across pointer wrap.
REQ-034 Overflow: occupancy=4, out_ready=0, pt_valid=1 -> overflow=1 sticky, contents unchanged; a load with load_ok=0 -> bad_load=1.
REQ-035 Streaming: 20 back-to-back loads with out_ready toggling 1/0 and load gated by load_ok -> all 20 plaintexts out in order, overflow=0, bad_load=0.
REQ-036 Reset mid-stream: rst_b=0 with occupancy=3, inflight=1 -> out_valid=0 and load_ok=1 asynchronously; a later pt_valid is accepted normally.
